// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester (core, DMA/debug) front end for a single-port
// data memory. Accept, memory and response stages form a fixed-latency
// pipeline: every granted access produces exactly one rvalid two cycles later.
module dmem_arbiter #(
  parameter int unsigned ADDR_LIMIT = 100
) (
  input  logic        clk,
  input  logic        rst,
  // core requester
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [2:0]  c_func3,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic        c_err,
  output logic [31:0] c_rdata,
  // DMA / debug requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_func3,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_err,
  output logic [31:0] d_rdata,
  // data memory port
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_func3,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] LIMIT = ADDR_LIMIT;

  // Arbitration pointer: which requester wins the next conflict.
  typedef enum logic {PRIO_CORE, PRIO_DMA} prio_t;
  prio_t prio;

  logic        grant_c;
  logic        grant_d;
  logic        accept;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_func3;
  logic        func_ok;
  logic        legal;

  // Memory-stage bookkeeping that the response stage needs.
  logic        s1_valid;
  logic        s1_owner_d;
  logic        s1_err;

  // Grant is combinational so a requester is accepted in the cycle it asks;
  // reset forces both grants low immediately.
  always_comb begin
    grant_c = 1'b0;
    grant_d = 1'b0;
    if (!rst) begin
      if (c_req && (!d_req || prio == PRIO_CORE)) begin
        grant_c = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  assign c_gnt  = grant_c;
  assign d_gnt  = grant_d;
  assign accept = grant_c | grant_d;

  // Select the winner's request fields and classify the access as legal or not.
  always_comb begin
    sel_we    = grant_d ? d_we    : c_we;
    sel_addr  = grant_d ? d_addr  : c_addr;
    sel_wdata = grant_d ? d_wdata : c_wdata;
    sel_func3 = grant_d ? d_func3 : c_func3;
    if (sel_we) begin
      func_ok = (sel_func3 == 3'b000) || (sel_func3 == 3'b001) ||
                (sel_func3 == 3'b010);
    end else begin
      func_ok = (sel_func3 == 3'b000) || (sel_func3 == 3'b001) ||
                (sel_func3 == 3'b010) || (sel_func3 == 3'b100) ||
                (sel_func3 == 3'b101);
    end
    legal = func_ok && (sel_addr < LIMIT);
  end

  // Pointer flips to the other requester after each grant; idle cycles keep it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= PRIO_CORE;
    end else if (grant_c) begin
      prio <= PRIO_DMA;
    end else if (grant_d) begin
      prio <= PRIO_CORE;
    end
  end

  // Memory stage: drive the memory port only for legal accesses, zeros otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_owner_d <= 1'b0;
      s1_err     <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_func3  <= '0;
    end else begin
      s1_valid   <= accept;
      s1_owner_d <= grant_d;
      s1_err     <= accept && !legal;
      mem_rd_en  <= accept && legal && !sel_we;
      mem_wr_en  <= accept && legal && sel_we;
      mem_addr   <= (accept && legal) ? sel_addr  : '0;
      mem_wdata  <= (accept && legal) ? sel_wdata : '0;
      mem_func3  <= (accept && legal) ? sel_func3 : '0;
    end
  end

  // Response stage: route the memory-stage result to its owner only, so the
  // idle requester always sees zero rvalid/rdata/err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_rvalid <= 1'b0;
      c_err    <= 1'b0;
      c_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
    end else begin
      c_rvalid <= s1_valid && !s1_owner_d;
      c_err    <= s1_valid && !s1_owner_d && s1_err;
      c_rdata  <= (s1_valid && !s1_owner_d && mem_rd_en) ? mem_rdata : '0;
      d_rvalid <= s1_valid && s1_owner_d;
      d_err    <= s1_valid && s1_owner_d && s1_err;
      d_rdata  <= (s1_valid && s1_owner_d && mem_rd_en) ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven check of grant, memory port and response
// pipeline of dmem_arbiter, plus hand-written reset-in-flight sequence.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [2:0]  c_func3, d_func3;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_func3;

  int checks = 0;
  int fails  = 0;

  // stimulus: {req,we} pairs
  localparam logic [1:0] NO = 2'b00, RD = 2'b10, WR = 2'b11;
  // expected grant {c,d}
  localparam logic [1:0] GN = 2'b00, GC = 2'b10, GD = 2'b01;
  // expected mem enables {rd,wr}
  localparam logic [1:0] E0 = 2'b00, ER = 2'b10, EW = 2'b01;
  // expected response {rvalid,err}
  localparam logic [1:0] RN = 2'b00, RV = 2'b10, RE = 2'b11;

  typedef struct {
    logic [1:0]  c_rw;
    logic [31:0] c_a;
    logic [31:0] c_wd;
    logic [2:0]  c_f3;
    logic [1:0]  d_rw;
    logic [31:0] d_a;
    logic [31:0] d_wd;
    logic [2:0]  d_f3;
  } stim_t;

  typedef struct {
    logic [1:0]  gnt;
    logic [1:0]  en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [1:0]  c_ve;
    logic [31:0] c_rd;
    logic [1:0]  d_ve;
    logic [31:0] d_rd;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  dmem_arbiter #(.ADDR_LIMIT(100)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_func3(c_func3), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_err(c_err),
    .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_func3(d_func3), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err),
    .d_rdata(d_rdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory with asynchronous read and write on the clock edge; preloaded
  // on the first edge.
  logic [31:0] mem_model [0:127];
  logic        mem_loaded = 1'b0;

  assign mem_rdata = (mem_addr < 32'd128) ? mem_model[mem_addr[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 128; i++) mem_model[i] <= 32'h0;
      mem_model[3]  <= 32'hA5A5_0003;
      mem_model[5]  <= 32'hDEAD_BEEF;
      mem_model[9]  <= 32'h9999_0009;
      mem_model[99] <= 32'h6363_6363;
      mem_loaded    <= 1'b1;
    end else if (mem_wr_en && mem_addr < 32'd128) begin
      mem_model[mem_addr[6:0]] <= mem_wdata;
    end
  end

  function automatic logic [159:0] all_outs();
    return {c_gnt, d_gnt, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_func3,
            c_rvalid, c_err, c_rdata, d_rvalid, d_err, d_rdata};
  endfunction

  task automatic apply_stimulus(input stim_t s);
    {c_req, c_we} = s.c_rw;
    c_addr  = s.c_a;
    c_wdata = s.c_wd;
    c_func3 = s.c_f3;
    {d_req, d_we} = s.d_rw;
    d_addr  = s.d_a;
    d_wdata = s.d_wd;
    d_func3 = s.d_f3;
  endtask

  task automatic check_output(input string name, input int idx,
                              input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s (%0d): actual %0h required %0h", name, idx, act, exp);
    end
  endtask

  localparam stim_t IDLE = '{NO, '0, '0, '0, NO, '0, '0, '0};
  localparam stim_t BOTH = '{RD, 32'd3, '0, 3'd2, RD, 32'd9, '0, 3'd0};

  initial begin
    vecs[0]  = '{'{RD, 32'd5, '0, 3'd2, NO, '0, '0, '0},
                 '{GC, E0, '0, '0, '0, RN, '0, RN, '0}};
    vecs[1]  = '{'{NO, '0, '0, '0, WR, 32'd7, 32'h1234_5678, 3'd2},
                 '{GD, ER, 32'd5, '0, 3'd2, RN, '0, RN, '0}};
    vecs[2]  = '{'{RD, 32'd7, '0, 3'd2, NO, '0, '0, '0},
                 '{GC, EW, 32'd7, 32'h1234_5678, 3'd2, RV, 32'hDEAD_BEEF, RN, '0}};
    vecs[3]  = '{IDLE, '{GN, ER, 32'd7, '0, 3'd2, RN, '0, RV, '0}};
    vecs[4]  = '{'{RD, 32'd100, '0, 3'd2, NO, '0, '0, '0},
                 '{GC, E0, '0, '0, '0, RV, 32'h1234_5678, RN, '0}};
    vecs[5]  = '{'{NO, '0, '0, '0, WR, 32'd3, 32'h5555_5555, 3'd4},
                 '{GD, E0, '0, '0, '0, RN, '0, RN, '0}};
    vecs[6]  = '{IDLE, '{GN, E0, '0, '0, '0, RE, '0, RN, '0}};
    vecs[7]  = '{IDLE, '{GN, E0, '0, '0, '0, RN, '0, RE, '0}};
    vecs[8]  = '{BOTH, '{GC, E0, '0, '0, '0, RN, '0, RN, '0}};
    vecs[9]  = '{BOTH, '{GD, ER, 32'd3, '0, 3'd2, RN, '0, RN, '0}};
    vecs[10] = '{BOTH, '{GC, ER, 32'd9, '0, 3'd0, RV, 32'hA5A5_0003, RN, '0}};
    vecs[11] = '{BOTH, '{GD, ER, 32'd3, '0, 3'd2, RN, '0, RV, 32'h9999_0009}};
    vecs[12] = '{IDLE, '{GN, ER, 32'd9, '0, 3'd0, RV, 32'hA5A5_0003, RN, '0}};
    vecs[13] = '{IDLE, '{GN, E0, '0, '0, '0, RN, '0, RV, 32'h9999_0009}};
    vecs[14] = '{'{NO, '0, '0, '0, RD, 32'd99, '0, 3'd5},
                 '{GD, E0, '0, '0, '0, RN, '0, RN, '0}};
    vecs[15] = '{'{RD, 32'd5, '0, 3'd3, NO, '0, '0, '0},
                 '{GC, ER, 32'd99, '0, 3'd5, RN, '0, RN, '0}};
    vecs[16] = '{IDLE, '{GN, E0, '0, '0, '0, RN, '0, RV, 32'h6363_6363}};
    vecs[17] = '{IDLE, '{GN, E0, '0, '0, '0, RE, '0, RN, '0}};
    vecs[18] = '{'{WR, 32'd20, 32'h0000_BEEF, 3'd1, NO, '0, '0, '0},
                 '{GC, E0, '0, '0, '0, RN, '0, RN, '0}};
    vecs[19] = '{IDLE, '{GN, EW, 32'd20, 32'h0000_BEEF, 3'd1, RN, '0, RN, '0}};
    vecs[20] = '{IDLE, '{GN, E0, '0, '0, '0, RV, '0, RN, '0}};

    // Reset with both requests up: nothing may be granted or driven.
    rst = 1'b1;
    apply_stimulus(BOTH);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_outputs", 0, all_outs(), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply_stimulus(vecs[i].s);
      @(negedge clk);
      check_output("gnt", i, {c_gnt, d_gnt}, vecs[i].e.gnt);
      check_output("mem", i, {mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_func3},
                   {vecs[i].e.en, vecs[i].e.addr, vecs[i].e.wdata, vecs[i].e.f3});
      check_output("c_rsp", i, {c_rvalid, c_err, c_rdata},
                   {vecs[i].e.c_ve, vecs[i].e.c_rd});
      check_output("d_rsp", i, {d_rvalid, d_err, d_rdata},
                   {vecs[i].e.d_ve, vecs[i].e.d_rd});
      @(posedge clk);
      #1;
    end
    check_output("halfword_write_landed", 0, mem_model[20], 32'h0000_BEEF);

    // Reset while a write is in its memory stage: it must be dropped.
    apply_stimulus('{NO, '0, '0, '0, WR, 32'd11, 32'hCAFE_F00D, 3'd2});
    @(negedge clk);
    check_output("mf_gnt", 0, {c_gnt, d_gnt}, GD);
    @(posedge clk);
    #1;
    apply_stimulus(IDLE);
    #2;
    rst = 1'b1;
    #1;
    check_output("mf_reset_outputs", 0, all_outs(), '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("mf_hold", k, all_outs(), '0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus('{RD, 32'd5, '0, 3'd2, RD, 32'd3, '0, 3'd2});
    @(negedge clk);
    check_output("mf_conflict1", 0, {c_gnt, d_gnt}, GC);
    check_output("mf_no_rvalid", 0, {c_rvalid, d_rvalid}, 2'b00);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("mf_conflict2", 0, {c_gnt, d_gnt}, GD);
    check_output("mf_no_rvalid", 1, {c_rvalid, d_rvalid}, 2'b00);
    @(posedge clk);
    #1;
    apply_stimulus(IDLE);
    @(negedge clk);
    check_output("mf_mem", 0, {mem_rd_en, mem_wr_en, mem_addr, mem_func3},
                 {ER, 32'd3, 3'd2});
    check_output("mf_c_rsp", 0, {c_rvalid, c_err, c_rdata}, {RV, 32'hDEAD_BEEF});
    check_output("mf_d_rsp", 0, {d_rvalid, d_err, d_rdata}, {RN, 32'h0});
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("mf_c_rsp", 1, {c_rvalid, c_err, c_rdata}, {RN, 32'h0});
    check_output("mf_d_rsp", 1, {d_rvalid, d_err, d_rdata}, {RV, 32'hA5A5_0003});
    check_output("mf_dropped_write", 0, mem_model[11], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_LIMIT, default 100, number of valid word entries in the data memory; addresses at or above it are out of range.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 c_req / c_we  input  1 each  core request valid; core write (1) or read (0).
REQ-005 c_addr / c_wdata  input  32 each  core address; core store data.
REQ-006 c_func3  input  3  core access size/sign code.
REQ-007 c_gnt  output  1  core request accepted this cycle.
REQ-008 c_rvalid / c_err  output  1 each  core response valid; core response error.
REQ-009 c_rdata  output  32  core read data.
REQ-010 d_req, d_we, d_addr, d_wdata, d_func3, d_gnt, d_rvalid, d_err, d_rdata  same directions and widths as REQ-004..009, for the DMA/debug requester.
REQ-011 mem_rd_en / mem_wr_en  output  1 each  data memory read/write enable.
REQ-012 mem_addr / mem_wdata  output  32 each  data memory address and write data.
REQ-013 mem_func3  output  3  data memory size/sign code.
REQ-014 mem_rdata  input  32  data memory asynchronous read data.

Function
REQ-015 Three-stage pipeline: accept (cycle T), memory (T+1), response (T+2); one new access accepted per cycle, no bubbles.
REQ-016 Accept: a requester holding req high is granted in the same cycle; gnt is combinational from req and the arbitration pointer and is high for exactly one cycle per accepted access.
REQ-017 Only one grant per cycle; if only one req is high, that requester is granted.
REQ-018 If both req are high, the requester not granted most recently wins; the pointer updates only on a grant.
REQ-019 After reset the pointer favours the core (first conflict goes to core).
REQ-020 A requester keeps req, we, addr, wdata and func3 stable until gnt; the arbiter samples the winner's fields at the edge ending T.
REQ-021 Legality check at accept: illegal if addr >= ADDR_LIMIT; if a write with func3 not in {000,001,010}; if a read with func3 not in {000,001,010,100,101}.
REQ-022 Memory stage (T+1): for a legal access, registered mem_rd_en = ~we, mem_wr_en = we, mem_addr/mem_wdata/mem_func3 = sampled values.
REQ-023 An illegal access or an empty stage drives mem_rd_en = mem_wr_en = 0 and mem_addr/mem_wdata/mem_func3 = 0.
REQ-024 At the end of T+1 the response register captures mem_rdata for legal reads, 0 for writes and illegal accesses, plus the owner ID and an error flag.
REQ-025 Response (T+2): the owner's rvalid pulses for one cycle with rdata from REQ-024 and err = illegal flag; the other requester's rvalid, rdata and err are 0.
REQ-026 Every accepted access, including writes and illegal accesses, produces exactly one rvalid, in acceptance order; fixed latency 2 cycles from gnt.
REQ-027 Simultaneous read and write to the same address in consecutive cycles: memory order equals acceptance order; a read accepted after a write sees the written data.
REQ-028 When neither rvalid is high, c_rdata, d_rdata, c_err and d_err are 0.

Reset
REQ-029 When rst is asserted, all outputs are 0 immediately and asynchronously, both pipeline stages are emptied, and the pointer returns to core priority.
REQ-030 Accesses in flight when rst asserts are dropped: no rvalid and no memory write after reset.
REQ-031 The first accept is possible on the first posedge clk after rst deasserts.

Verification
REQ-032 Single core read: c_req=1, c_we=0, c_addr=5, c_func3=010, mem[5]=0xDEADBEEF -> c_gnt at T, mem_rd_en=1 and mem_addr=5 at T+1, c_rvalid=1 and c_rdata=0xDEADBEEF at T+2.
REQ-033 Conflict: both req held for 4 cycles, after reset -> grants in order c, d, c, d; rvalids follow 2 cycles behind, in the same order.
REQ-034 Write then read: d write addr 7, func3 010, wdata 0x12345678 at T; c read addr 7 at T+1 -> c_rdata=0x12345678 at T+3.
REQ-035 Illegal accesses: c read addr 100 (ADDR_LIMIT=100); d write func3 100 -> mem enables stay 0; err=1 and rdata=0 at each rvalid.
REQ-036 Reset mid-flight: grant a write at T; assert rst during T+1 before the edge -> outputs 0 at once, mem_wr_en never high, no rvalid; after release the first conflict grants core.
